// File: rtl/pac_frame_tx.sv
// pac_frame_tx: snapshots all PAC strengths/classes on a trigger and streams them as one framed packet.
// Optional timestamp word enabled by defining PAC_FRAME_TIMESTAMP_EN.
module pac_frame_tx #(
    parameter int WIDTH     = 18,
    parameter int NUM_PAIRS = 10,
    parameter int DIV_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_en,
    input  logic [NUM_PAIRS*WIDTH-1:0]   pac_flat,
    input  logic [NUM_PAIRS*2-1:0]       class_flat,
    input  logic                         snap_req,
    input  logic [DIV_W-1:0]             period,
    output logic [23:0]                  tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         tx_last,
    output logic                         busy,
    output logic [7:0]                   frame_seq,
    output logic [7:0]                   overrun_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_PAIRS - 1);

`ifdef PAC_FRAME_TIMESTAMP_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_TS, S_PAIR, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAIR, S_CSUM} state_t;
`endif

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                        state_q, state_d;
    logic [3:0]                    idx_q, idx_d;
    logic [23:0]                   csum_q;
    logic [7:0]                    frame_seq_q;
    logic [7:0]                    overrun_q;
    logic [DIV_W-1:0]              timer_q;
    logic [NUM_PAIRS*WIDTH-1:0]    pac_snap_p0;
    logic [NUM_PAIRS*2-1:0]        class_snap_p0;
    logic signed [WIDTH-1:0]       pac_sel;
    logic [1:0]                    class_sel;
    logic                          timer_fire;
    logic                          trigger;
    logic                          xfer;
    logic                          start;

`ifdef PAC_FRAME_TIMESTAMP_EN
    logic [23:0]                   ts_q;
    logic [23:0]                   ts_snap_p0;
`endif

    assign timer_fire = (period != '0) && (timer_q >= period - DIV_W'(1));
    assign trigger    = clk_en & (snap_req | timer_fire);
    assign busy       = (state_q != S_IDLE);
    assign tx_valid   = busy;
    assign xfer       = tx_valid & tx_ready & clk_en;
    assign start      = trigger & ~busy;
    assign frame_seq  = frame_seq_q;
    assign overrun_cnt = overrun_q;

    assign pac_sel   = pac_snap_p0[idx_q*WIDTH +: WIDTH];
    assign class_sel = class_snap_p0[idx_q*2 +: 2];

    // Stage p0: trigger-time snapshot; data only, so no reset needed
    always_ff @(posedge clk) begin
        if (start) begin
            pac_snap_p0   <= pac_flat;
            class_snap_p0 <= class_flat;
`ifdef PAC_FRAME_TIMESTAMP_EN
            ts_snap_p0    <= ts_q;
`endif
        end
    end

    // Control state: FSM, word index, checksum, counters and timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            csum_q      <= '0;
            frame_seq_q <= '0;
            overrun_q   <= '0;
            timer_q     <= '0;
`ifdef PAC_FRAME_TIMESTAMP_EN
            ts_q        <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (clk_en) begin
                if (period == '0 || timer_fire) begin
                    timer_q <= '0;
                end else begin
                    timer_q <= timer_q + DIV_W'(1);
                end
`ifdef PAC_FRAME_TIMESTAMP_EN
                ts_q <= ts_q + 24'd1;
`endif
            end
            if (start) begin
                csum_q <= '0;
            end else if (xfer && state_q != S_CSUM) begin
                csum_q <= csum_q ^ tx_data;
            end
            if (xfer && state_q == S_CSUM) begin
                frame_seq_q <= frame_seq_q + 8'd1;
            end
            // A trigger seen while a frame is in flight is lost, not queued
            if (trigger && busy) begin
                overrun_q <= sat_inc8(overrun_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tx_data = '0;
        tx_last = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                tx_data = {8'hA5, frame_seq_q, 8'(NUM_PAIRS)};
                if (xfer) begin
`ifdef PAC_FRAME_TIMESTAMP_EN
                    state_d = S_TS;
`else
                    state_d = S_PAIR;
`endif
                    idx_d = '0;
                end
            end
`ifdef PAC_FRAME_TIMESTAMP_EN
            S_TS: begin
                tx_data = ts_snap_p0;
                if (xfer) begin
                    state_d = S_PAIR;
                    idx_d   = '0;
                end
            end
`endif
            S_PAIR: begin
                tx_data = 24'({idx_q, class_sel, pac_sel});
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_CSUM;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_CSUM: begin
                tx_data = csum_q;
                tx_last = 1'b1;
                if (xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pac_frame_tx.sv
// Self-checking bench for pac_frame_tx: frame-level reference model plus hand-computed literal expectations.
module tb_pac_frame_tx;
    localparam int WIDTH = 18;
    localparam int NP    = 10;
    localparam int DIV_W = 16;
`ifdef PAC_FRAME_TIMESTAMP_EN
    localparam int FW = NP + 3;
`else
    localparam int FW = NP + 2;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    clk_en = 1'b0;
    logic [NP*WIDTH-1:0]     pac_flat = '0;
    logic [NP*2-1:0]         class_flat = '0;
    logic                    snap_req = 1'b0;
    logic [DIV_W-1:0]        period = '0;
    logic [23:0]             tx_data;
    logic                    tx_valid;
    logic                    tx_ready = 1'b0;
    logic                    tx_last;
    logic                    busy;
    logic [7:0]              frame_seq;
    logic [7:0]              overrun_cnt;

    pac_frame_tx #(.WIDTH(WIDTH), .NUM_PAIRS(NP), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .pac_flat(pac_flat),
        .class_flat(class_flat), .snap_req(snap_req), .period(period),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_last(tx_last), .busy(busy), .frame_seq(frame_seq), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [23:0] expq[$];
    logic [23:0] xlog[$];
    int          hdr_cyc[$];
    int          seq_m = 0, ovr_m = 0, timer_m = 0, ts_m = 0, cyc = 0;
    bit          mb, fire, trig, p_stall = 1'b0;
    logic [23:0] p_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic push_frame();
        logic [23:0] w, cs;
        cs = '0;
        w = {8'hA5, 8'(seq_m), 8'(NP)};
        expq.push_back(w); cs ^= w;
`ifdef PAC_FRAME_TIMESTAMP_EN
        w = 24'(ts_m);
        expq.push_back(w); cs ^= w;
`endif
        for (int i = 0; i < NP; i++) begin
            w = {4'(i), class_flat[i*2 +: 2], pac_flat[i*WIDTH +: WIDTH]};
            expq.push_back(w); cs ^= w;
        end
        expq.push_back(cs);
    endtask

    // compare process: checks outputs, then advances the model by the coming edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            expq.delete();
            seq_m = 0; ovr_m = 0; timer_m = 0; ts_m = 0; p_stall = 1'b0;
            chk("rst_valid", 32'(tx_valid), 32'(0));
            chk("rst_data", 32'(tx_data), 32'(0));
            chk("rst_last", 32'(tx_last), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_seq", 32'(frame_seq), 32'(0));
            chk("rst_ovr", 32'(overrun_cnt), 32'(0));
        end else begin
            mb = (expq.size() != 0);
            chk("valid", 32'(tx_valid), 32'(mb));
            chk("busy", 32'(busy), 32'(mb));
            chk("seq", 32'(frame_seq), 32'(seq_m));
            chk("ovr", 32'(overrun_cnt), 32'(ovr_m));
            if (mb) begin
                chk("data", 32'(tx_data), 32'(expq[0]));
                chk("last", 32'(tx_last), 32'(expq.size() == 1));
            end
            if (p_stall) chk("stable", 32'(tx_data), 32'(p_data));
            p_stall = tx_valid && !(tx_ready && clk_en);
            p_data  = tx_data;
            if (clk_en) begin
                fire = (period != 0) && (timer_m >= int'(period) - 1);
                trig = snap_req || fire;
                if (period == 0 || fire) timer_m = 0; else timer_m++;
                if (trig) begin
                    if (mb) begin
                        if (ovr_m < 255) ovr_m++;
                    end else begin
                        push_frame();
                    end
                end
                if (mb && tx_ready) begin
                    xlog.push_back(tx_data);
                    if (expq.size() == FW) hdr_cyc.push_back(cyc);
                    void'(expq.pop_front());
                    if (expq.size() == 0) seq_m = (seq_m + 1) % 256;
                end
                ts_m++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_snap();
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || expq.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'(0));
    endtask

    task automatic set_pac(input logic [WIDTH-1:0] v, input logic [1:0] c);
        for (int i = 0; i < NP; i++) begin
            pac_flat[i*WIDTH +: WIDTH] = v;
            class_flat[i*2 +: 2] = c;
        end
    endtask

    int s, h0, n;

    initial begin
        // 1: reset then one frame at full rate
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        clk_en = 1'b1;
        tx_ready = 1'b1;
        set_pac(18'd16384, 2'b10);
        tick();
        s = xlog.size();
        pulse_snap();
        wait_idle(200);
        chk("t1_words", 32'(xlog.size() - s), 32'(FW));
`ifndef PAC_FRAME_TIMESTAMP_EN
        chk("t1_hdr", 32'(xlog[s]), 32'h00A5000A);
        chk("t1_pair0", 32'(xlog[s+1]), 32'h00084000);
        chk("t1_pair9", 32'(xlog[s+10]), 32'h00984000);
        chk("t1_csum", 32'(xlog[s+11]), 32'h00B5000A);
`endif
        chk("t1_seq", 32'(frame_seq), 32'd1);

        // 2: same frame with tx_ready toggling each cycle
        s = xlog.size();
        pulse_snap();
        n = 0;
        while (busy && n < 200) begin
            tx_ready = ~tx_ready;
            tick();
            n++;
        end
        tx_ready = 1'b1;
        wait_idle(50);
        chk("t2_words", 32'(xlog.size() - s), 32'(FW));
`ifndef PAC_FRAME_TIMESTAMP_EN
        chk("t2_hdr", 32'(xlog[s]), 32'h00A5010A);
        chk("t2_pair3", 32'(xlog[s+4]), 32'h00384000);
        chk("t2_csum", 32'(xlog[s+11]), 32'h00B5010A);
`endif

        // 3: inputs cleared right after the trigger do not leak into the frame
        s = xlog.size();
        pulse_snap();
        set_pac('0, 2'b00);
        wait_idle(200);
`ifndef PAC_FRAME_TIMESTAMP_EN
        chk("t3_pair0", 32'(xlog[s+1]), 32'h00084000);
        chk("t3_pair7", 32'(xlog[s+8]), 32'h00784000);
`endif
        set_pac(18'd16384, 2'b10);

        // 4: triggers during a frame are dropped and counted, saturating at 255
        s = xlog.size();
        pulse_snap();
        tick(); pulse_snap();
        tick(); pulse_snap();
        tick(); pulse_snap();
        wait_idle(200);
        chk("t4_words", 32'(xlog.size() - s), 32'(FW));
        chk("t4_ovr3", 32'(overrun_cnt), 32'd3);
        tx_ready = 1'b0;
        pulse_snap();
        snap_req = 1'b1;
        repeat (300) tick();
        snap_req = 1'b0;
        chk("t4_ovr_sat", 32'(overrun_cnt), 32'd255);
        tx_ready = 1'b1;
        wait_idle(200);

        // 5: periodic snapshots, period 0 silence, clk_en pause mid-frame
        h0 = hdr_cyc.size();
        period = 16'd100;
        repeat (350) tick();
        period = '0;
        wait_idle(200);
        chk("t5_nframes", 32'(hdr_cyc.size() - h0), 32'd3);
        for (int k = h0 + 1; k < hdr_cyc.size(); k++)
            chk("t5_spacing", 32'(hdr_cyc[k] - hdr_cyc[k-1]), 32'd100);
        s = xlog.size();
        repeat (1000) tick();
        chk("t5_silent", 32'(xlog.size() - s), 32'd0);
        pulse_snap();
        repeat (4) tick();
        clk_en = 1'b0;
        repeat (50) tick();
        chk("t5_paused_busy", 32'(busy), 32'd1);
        clk_en = 1'b1;
        wait_idle(200);
        chk("t5_words", 32'(xlog.size() - s), 32'(FW));

        // 6: asynchronous reset in the middle of a frame
        s = xlog.size();
        pulse_snap();
        n = 0;
        while (xlog.size() < s + 5 && n < 100) begin
            tick();
            n++;
        end
        chk("t6_reach_w5", 32'(xlog.size() - s), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("t6_valid_now", 32'(tx_valid), 32'd0);
        chk("t6_seq_now", 32'(frame_seq), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        s = xlog.size();
        pulse_snap();
        wait_idle(200);
        chk("t6_words", 32'(xlog.size() - s), 32'(FW));
        chk("t6_hdr", 32'(xlog[s]), 32'h00A5000A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
